fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 112 +++++++++++
 tb/tb_fetch_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect/flush handling and a
// registered instruction output stage. Optional counters enabled by FETCH_PERF_CNT_EN.
module fetch_ctrl #(
  parameter int unsigned     WORD      = 64,
  parameter int unsigned     INSTR_LEN = 32,
  parameter logic [WORD-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_src,
  input  logic [WORD-1:0]      branch_target,
  input  logic                 stall,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_ready,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic                 instr_valid,
  output logic [INSTR_LEN-1:0] instr,
  output logic [WORD-1:0]      instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [WORD-1:0]        pc_q, pc_d;
  logic [WORD-1:0]        redirect_pc;
  logic                   capture;
  logic                   imem_req_d;
  logic [WORD-1:0]        imem_addr_d;
  logic                   instr_valid_d;
  logic [INSTR_LEN-1:0]   instr_d;
  logic [WORD-1:0]        instr_pc_d;

  assign redirect_pc = {branch_target[WORD-1:2], 2'b00};
  // A response is only kept when it arrives in FETCH and no redirect wins the same cycle.
  assign capture     = (state_q == StFetch) && imem_ready && !pc_src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req    <= imem_req_d;
      imem_addr   <= imem_addr_d;
      instr_valid <= instr_valid_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (pc_src) begin
          state_d = imem_ready ? StFetch : StDrain;
        end else if (imem_ready && stall) begin
          state_d = StHold;
        end
      end
      StHold:  if (pc_src || !stall) state_d = StFetch;
      // The in-flight response must be swallowed before the redirected pc is issued.
      StDrain: if (imem_ready) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr;
    instr_pc_d    = instr_pc;
    instr_valid_d = instr_valid && stall;
    if (pc_src) begin
      pc_d          = redirect_pc;
      instr_valid_d = 1'b0;
    end else if (capture) begin
      instr_d       = imem_rdata;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      pc_d          = pc_q + WORD'(4);
    end
    imem_req_d  = (state_d == StFetch) || (state_d == StDrain);
    // DRAIN keeps presenting the abandoned address until its response shows up.
    imem_addr_d = (state_d == StFetch) ? pc_d : imem_addr;
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (capture)            perf_fetched <= perf_fetched + 32'd1;
      if (state_q == StHold)  perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised bench for fetch_ctrl against a behavioural fetch model and a latency-variable
// instruction memory; a second instance checks pc wrap-around from the top of the space.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_src = 1'b0;
  logic [63:0] branch_target = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  logic        w_req, w_ready = 1'b0, w_valid;
  logic [63:0] w_addr, w_ipc;
  logic [31:0] w_instr;

  always #5 clk = ~clk;

  fetch_ctrl u_dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
  );

  fetch_ctrl #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .pc_src(1'b0), .branch_target(64'h0), .stall(1'b0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready),
    .imem_rdata(32'hCAFE_F00D), .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_ipc)
  );

  int unsigned n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5EED_0001;
  endfunction

  // Behavioural fetch model: where the fetcher is, which pc comes next, what is on display.
  bit          m_boot, m_hold, m_drain, m_valid;
  logic [63:0] m_pc, m_addr, m_ipc;
  logic [31:0] m_instr;

  // Memory model: one transaction at a time, answered 1..3 cycles after it is first seen.
  bit          busy;
  int          mcnt, fix_lat;
  logic [63:0] maddr;
  logic [63:0] req_log[$];
  bit          w_seen_cap = 1'b0;

  task automatic model_reset();
    m_boot = 1; m_hold = 0; m_drain = 0; m_valid = 0;
    m_pc = 64'h0; m_addr = 64'h0; m_ipc = 64'h0; m_instr = 32'h0;
    busy = 0; mcnt = 0; req_log.delete();
  endtask

  task automatic model_update();
    logic [63:0] tgt;
    bit consumed;
    tgt = {branch_target[63:2], 2'b00};
    consumed = m_valid && !stall;
    if (m_boot) begin
      m_boot = 0;
      if (pc_src) m_pc = tgt;
    end else if (m_hold) begin
      if (pc_src) begin m_pc = tgt; m_valid = 0; m_hold = 0; end
      else if (!stall) begin m_valid = 0; m_hold = 0; end
    end else if (m_drain) begin
      if (pc_src) m_pc = tgt;
      if (imem_ready) m_drain = 0;
    end else begin
      if (pc_src) begin
        m_pc = tgt; m_valid = 0;
        if (!imem_ready) m_drain = 1;
      end else if (imem_ready) begin
        m_instr = imem_rdata; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 64'd4; m_hold = stall;
      end else if (consumed) begin
        m_valid = 0;
      end
    end
    if (!m_hold && !m_drain) m_addr = m_pc;
  endtask

  task automatic compare();
    check("imem_req", 64'(imem_req), 64'(!m_hold && !m_boot));
    check("imem_addr", imem_addr, m_addr);
    check("instr_valid", 64'(instr_valid), 64'(m_valid));
    check("instr", 64'(instr), 64'(m_instr));
    check("instr_pc", instr_pc, m_ipc);
    if (instr_valid) check("instr_data", 64'(instr), 64'(mem_word(instr_pc)));
  endtask

  task automatic mem_update();
    if (imem_ready) busy = 0;
    if (busy) begin
      check("req_stable", 64'(imem_req), 64'd1);
      check("addr_stable", imem_addr, maddr);
      mcnt--;
      imem_ready = (mcnt <= 0);
    end else if (imem_req) begin
      busy = 1; maddr = imem_addr; req_log.push_back(imem_addr);
      mcnt = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 3));
      imem_ready = 1'b0;
    end else begin
      imem_ready = 1'b0;
    end
    imem_rdata = imem_ready ? mem_word(maddr) : $urandom();
  endtask

  task automatic wrap_update();
    if (!w_seen_cap && w_valid) begin
      check("wrap_instr_pc", w_ipc, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_next_addr", w_addr, 64'h0);
      check("wrap_instr", 64'(w_instr), 64'hCAFE_F00D);
      w_seen_cap = 1'b1;
    end
    w_ready = w_req && !w_ready;
  endtask

  task automatic step();
    model_update();
    @(posedge clk); #1;
    compare();
    mem_update();
    wrap_update();
  endtask

  // Asserted away from the clock edge; outputs must clear with no edge in between.
  task automatic do_reset();
    reset = 1'b0; pc_src = 1'b0; stall = 1'b0; imem_ready = 1'b0; w_ready = 1'b0;
    #2;
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_imem_addr", imem_addr, 64'h0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_pc", instr_pc, 64'h0);
    check("rst_wrap_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    int base;
    #1;
    // Sequential fetch with single-cycle memory latency.
    fix_lat = 1;
    do_reset();
    for (int i = 0; i < 12; i++) step();
    check("seq_addr0", (req_log.size() > 0) ? req_log[0] : 64'hX, 64'h0);
    check("seq_addr1", (req_log.size() > 1) ? req_log[1] : 64'hX, 64'h4);
    check("seq_addr2", (req_log.size() > 2) ? req_log[2] : 64'hX, 64'h8);

    // Three stall cycles starting with the first capture.
    do_reset();
    for (int i = 0; i < 10 && !imem_ready; i++) step();
    check("wait_first_ready", 64'(imem_ready), 64'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    stall = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("resume_addr", (req_log.size() > 1) ? req_log[1] : 64'hX, 64'h4);

    // Redirect while the request to 0x8 is still outstanding.
    fix_lat = 3;
    do_reset();
    for (int i = 0; i < 30 && !(busy && maddr == 64'h8); i++) step();
    check("wait_req8", 64'(busy && maddr == 64'h8), 64'd1);
    base = req_log.size();
    pc_src = 1'b1; branch_target = 64'h103;
    step();
    pc_src = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("drain_next_addr", (req_log.size() > base) ? req_log[base] : 64'hX, 64'h100);

    // Redirect coincident with the response from 0x8.
    fix_lat = 1;
    do_reset();
    for (int i = 0; i < 30 && !(imem_ready && maddr == 64'h8); i++) step();
    check("wait_rdy8", 64'(imem_ready && maddr == 64'h8), 64'd1);
    base = req_log.size();
    pc_src = 1'b1; branch_target = 64'h100;
    step();
    pc_src = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("discard_next_addr", (req_log.size() > base) ? req_log[base] : 64'hX, 64'h100);

    // Random traffic with occasional mid-request resets.
    fix_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      if (imem_req && $urandom_range(0, 299) == 0) do_reset();
      stall = ($urandom_range(0, 9) < 3);
      pc_src = ($urandom_range(0, 99) < 8);
      if (m_drain && imem_ready) pc_src = 1'b0;
      branch_target = ($urandom_range(0, 3) != 0) ? {$urandom(), $urandom()}
                                                  : {60'hFFFF_FFFF_FFFF_FFF, 4'($urandom())};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
